alu_share_sched: RTL



---
 rtl/alu_share_sched.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_share_sched.sv
// Round-robin scheduler sharing one registered-input ALU among NUM_REQ requesters.
// Optional feature: define ALU_SHARE_SCHED_FUNC_CHECK_EN to flag function codes above 5.
module alu_share_sched #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FUNC_WIDTH = 3,
    parameter int unsigned ID_WIDTH   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*FUNC_WIDTH-1:0]    req_func,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_b,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_c,
    output logic [FUNC_WIDTH-1:0]            alu_func,
    output logic [DATA_WIDTH-1:0]            alu_in1,
    output logic [DATA_WIDTH-1:0]            alu_in2,
    output logic [DATA_WIDTH-1:0]            alu_in3,
    input  logic [DATA_WIDTH-1:0]            alu_out,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ID_WIDTH-1:0]              rsp_id,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             rsp_err,
    output logic                             busy
);
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state, state_nxt;
    logic [ID_WIDTH-1:0]   ptr, grant_idx;
    logic                  grant_found, can_accept, accept;
    logic [FUNC_WIDTH-1:0] sel_func;
    logic [DATA_WIDTH-1:0] sel_a, sel_b, sel_c;
    int unsigned           idx;
    logic [IW-1:0]         idx_n;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        idx_n       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx   = (32'(ptr) + k) % NUM_REQ;
            idx_n = IW'(idx);
            if (!grant_found && req_valid[idx_n]) begin
                grant_found = 1'b1;
                grant_idx   = ID_WIDTH'(idx);
            end
        end
    end

    assign can_accept = rst && ((state == IDLE) || ((state == RESP) && rsp_ready));
    assign accept     = can_accept && grant_found;

    always_comb begin
        req_ready = '0;
        sel_func  = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_c     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == ID_WIDTH'(k)) begin
                req_ready[k] = accept;
                sel_func     = req_func[k*FUNC_WIDTH +: FUNC_WIDTH];
                sel_a        = req_a[k*DATA_WIDTH +: DATA_WIDTH];
                sel_b        = req_b[k*DATA_WIDTH +: DATA_WIDTH];
                sel_c        = req_c[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = accept ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ALU_SHARE_SCHED_FUNC_CHECK_EN
    logic func_bad, err_pend, rsp_err_q;
    assign func_bad = 32'(sel_func) > 5;
    assign rsp_err  = rsp_err_q;
`else
    assign rsp_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= ID_WIDTH'(NUM_REQ - 1);
            alu_func <= '0;
            alu_in1  <= '0;
            alu_in2  <= '0;
            alu_in3  <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
`ifdef ALU_SHARE_SCHED_FUNC_CHECK_EN
            err_pend  <= 1'b0;
            rsp_err_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                ptr     <= grant_idx;
                rsp_id  <= grant_idx;
                alu_in1 <= sel_a;
                alu_in2 <= sel_b;
                alu_in3 <= sel_c;
`ifdef ALU_SHARE_SCHED_FUNC_CHECK_EN
                alu_func <= func_bad ? '0 : sel_func;
                err_pend <= func_bad;
`else
                alu_func <= sel_func;
`endif
            end
            if (state == EXEC) begin
`ifdef ALU_SHARE_SCHED_FUNC_CHECK_EN
                rsp_data  <= err_pend ? '0 : alu_out;
                rsp_err_q <= err_pend;
`else
                rsp_data  <= alu_out;
`endif
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule
